// File: rtl/gray_pkg.sv
// Shared types, default widths and gray/binary helpers for the gray sum accumulator.
package gray_pkg;

  localparam int unsigned GRAY_W_DEF      = 5;
  localparam int unsigned NUM_SAMPLES_DEF = 16;
  localparam int unsigned ACC_W_DEF       = 9;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} gacc_state_t;

  // Each binary bit is the XOR of all gray bits at or above it: a prefix-XOR scan from the top.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] b;
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    b = g & mask;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational gray-to-binary converter of parameterised width.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int unsigned W = GRAY_W_DEF
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(32'(gray), W));

endmodule

// File: rtl/gray_sum_accumulator.sv
// Accumulates a batch of gray-coded sums into a saturating binary total with valid/ready I/O.
// Optional gray-coded total output enabled by defining GRAY_SUM_GRAY_OUT_EN.
module gray_sum_accumulator
  import gray_pkg::*;
#(
  parameter int unsigned GRAY_W      = GRAY_W_DEF,
  parameter int unsigned NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GRAY_W-1:0] in_gray,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              overflow,
  output logic              busy
`ifdef GRAY_SUM_GRAY_OUT_EN
  , output logic [ACC_W-1:0] out_gray
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

  gacc_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [GRAY_W-1:0] in_bin;
  logic [ACC_W:0]   sum_ext;

  gray2bin_conv #(
    .W(GRAY_W)
  ) u_conv (
    .gray(in_gray),
    .bin (in_bin)
  );

  // One spare bit catches any carry out of the accumulator for saturation.
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_bin);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (sum_ext[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
          end
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode only the state register, so nothing reaches them from the inputs.
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;

`ifdef GRAY_SUM_GRAY_OUT_EN
  logic [ACC_W-1:0] out_gray_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_gray_q <= '0;
    end else begin
      out_gray_q <= ACC_W'(bin2gray(32'(acc_d)));
    end
  end

  assign out_gray = out_gray_q;
`endif

endmodule

// File: tb/tb_gray_sum_accumulator.sv
// Scoreboard bench: two instances (ACC_W 9 and 8) share stimulus; monitors check each batch total.
module tb_gray_sum_accumulator;

  typedef struct {
    logic [8:0] sum;
    logic       ovf;
    logic [8:0] gray;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, out_ready;
  logic [4:0] in_gray;

  logic       in_ready9, out_valid9, overflow9, busy9;
  logic [8:0] out_sum9, out_gray9;
  logic       in_ready8, out_valid8, overflow8, busy8;
  logic [7:0] out_sum8, out_gray8;

  exp_t q9[$];
  exp_t q8[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gray_sum_accumulator #(.GRAY_W(5), .NUM_SAMPLES(16), .ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready9),
    .in_gray(in_gray), .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
    .overflow(overflow9), .busy(busy9)
`ifdef GRAY_SUM_GRAY_OUT_EN
    , .out_gray(out_gray9)
`endif
  );

  gray_sum_accumulator #(.GRAY_W(5), .NUM_SAMPLES(16), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
    .in_gray(in_gray), .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .overflow(overflow8), .busy(busy8)
`ifdef GRAY_SUM_GRAY_OUT_EN
    , .out_gray(out_gray8)
`endif
  );

`ifndef GRAY_SUM_GRAY_OUT_EN
  assign out_gray9 = '0;
  assign out_gray8 = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_batch(input logic [8:0] s9, input logic o9, input logic [8:0] g9,
                              input logic [8:0] s8, input logic o8, input logic [8:0] g8);
    q9.push_back('{sum: s9, ovf: o9, gray: g9});
    q8.push_back('{sum: s8, ovf: o8, gray: g8});
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beats(input logic [4:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_gray  = g;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (busy9 || busy8); i++) step();
    check({name, "_drained"}, {30'd0, busy9, busy8}, 32'd0);
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid9 && out_ready) begin
      if (q9.size() == 0) check("mon9_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q9.pop_front();
        check("mon9_sum", 32'(out_sum9), 32'(e.sum));
        check("mon9_ovf", 32'(overflow9), 32'(e.ovf));
`ifdef GRAY_SUM_GRAY_OUT_EN
        check("mon9_gray", 32'(out_gray9), 32'(e.gray));
`endif
      end
    end
    if (rst_n && out_valid8 && out_ready) begin
      if (q8.size() == 0) check("mon8_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("mon8_sum", 32'(out_sum8), 32'(e.sum));
        check("mon8_ovf", 32'(overflow8), 32'(e.ovf));
`ifdef GRAY_SUM_GRAY_OUT_EN
        check("mon8_gray", 32'(out_gray8), 32'(e.gray));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_gray = '0;
    #3;
    check("reset_outputs9", {in_ready9, out_valid9, overflow9, busy9, out_sum9, out_gray9},
          32'd0);
    check("reset_outputs8", {in_ready8, out_valid8, overflow8, busy8, out_sum8, out_gray8},
          32'd0);
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    step();
    check("idle_ignores_valid", {30'd0, busy9, in_ready9}, 32'd0);
    in_valid = 1'b0;

    // Batch 1: 16 x gray 00001 -> 16; latency of one cycle after the last beat.
    expect_batch(9'd16, 1'b0, 9'h018, 9'd16, 1'b0, 9'h018);
    do_start();
    check("collect_in_ready", {31'd0, in_ready9}, 32'd1);
    beats(5'b00001, 15);
    check("no_valid_before_last", {30'd0, out_valid9, out_valid8}, 32'd0);
    beats(5'b00001, 1);
    check("valid_after_last", {30'd0, out_valid9, out_valid8}, 32'd3);
    check("ready_drops_in_hold", {30'd0, in_ready9, in_ready8}, 32'd0);
    drain("b1");

    // Batch 2: 16 x gray 10000 (31) -> 496 fits 9 bits, saturates 8 bits at 255.
    expect_batch(9'd496, 1'b0, 9'h108, 9'd255, 1'b1, 9'h080);
    do_start();
    beats(5'b10000, 16);
    drain("b2");
    check("ovf_sticky_after_handshake", {31'd0, overflow8}, 32'd1);

    // Batch 3: mixed values with idle gaps -> 21 + 2 = 23; start clears overflow.
    expect_batch(9'd23, 1'b0, 9'h01C, 9'd23, 1'b0, 9'h01C);
    do_start();
    check("start_clears_ovf", {31'd0, overflow8}, 32'd0);
    beats(5'b11111, 1);
    step();
    beats(5'b00011, 1);
    step();
    step();
    beats(5'b00000, 13);
    check("gaps_do_not_count", {31'd0, out_valid9}, 32'd0);
    beats(5'b00000, 1);
    check("gaps_last_beat", {31'd0, out_valid9}, 32'd1);
    drain("b3");

    // Batch 4: stall in HOLD with in_valid high; start during handshake is ignored.
    expect_batch(9'd16, 1'b0, 9'h018, 9'd16, 1'b0, 9'h018);
    do_start();
    beats(5'b00001, 16);
    in_valid = 1'b1;
    in_gray  = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_stable", {out_valid9, in_ready9, out_sum9}, {2'b10, 9'd16});
    end
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_accept", {out_valid9, busy9, out_sum9}, {2'b00, 9'd16});
    step();
    check("start_at_handshake_ignored", {31'd0, busy9}, 32'd0);

    // Batch 5: start pulse inside COLLECT must not restart the batch.
    expect_batch(9'd16, 1'b0, 9'h018, 9'd16, 1'b0, 9'h018);
    do_start();
    beats(5'b00001, 3);
    do_start();
    beats(5'b00001, 13);
    check("start_in_collect_ignored", {31'd0, out_valid9}, 32'd1);
    drain("b5");

    // Batch 6: reset after 7 beats, then a fresh batch counts from zero.
    do_start();
    beats(5'b00001, 7);
    rst_n = 1'b0;
    #1;
    check("midreset9", {in_ready9, out_valid9, overflow9, busy9, out_sum9, out_gray9}, 32'd0);
    check("midreset8", {in_ready8, out_valid8, overflow8, busy8, out_sum8, out_gray8}, 32'd0);
    step();
    rst_n = 1'b1;
    expect_batch(9'd16, 1'b0, 9'h018, 9'd16, 1'b0, 9'h018);
    do_start();
    beats(5'b00001, 15);
    check("restart_count_15", {31'd0, out_valid9}, 32'd0);
    beats(5'b00001, 1);
    check("restart_count_16", {31'd0, out_valid9}, 32'd1);
    drain("b6");

    step();
    check("scoreboard_empty", 32'(q9.size() + q8.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
